// File: rtl/ads131a0x_spi_responder_if.sv
// SPI pins between an ADS131A0X master and the converter-side responder.
interface ads131a0x_spi_responder_if;
  logic SPI_SCLK;
  logic SPI_CS;
  logic SPI_MOSI;
  logic SPI_MISO;

  modport master (
    output SPI_SCLK,
    output SPI_CS,
    output SPI_MOSI,
    input  SPI_MISO
  );

  modport slave (
    input  SPI_SCLK,
    input  SPI_CS,
    input  SPI_MOSI,
    output SPI_MISO
  );
endinterface

// File: rtl/ads131a0x_spi_responder.sv
// ADS131A0X device-side SPI model: command decode, status/data return, DRDY.
module ads131a0x_spi_responder #(
  parameter int         WORD_BITS   = 24,
  parameter int         NUM_CH      = 4,
  parameter int         DRDY_PERIOD = 2000,
  parameter logic [7:0] REG_ID_MSB  = 8'h04
) (
  input  logic                        system_clock,
  input  logic                        reset,
  ads131a0x_spi_responder_if.slave    spi,
  output logic                        drdy_n,
  input  logic [NUM_CH*WORD_BITS-1:0] ch_data,
  output logic                        locked,
  output logic                        cmd_valid,
  output logic [15:0]                 cmd_word,
  output logic                        frame_error
);

  localparam int BW = $clog2(WORD_BITS);
  localparam int CW = (DRDY_PERIOD > 1) ? $clog2(DRDY_PERIOD) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DECODE
  } state_e;

  state_e state_q, state_d;

  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  logic [WORD_BITS-1:0]        shift_q;
  logic [WORD_BITS-1:0]        rx_q;
  logic [BW-1:0]               bit_cnt_q;
  logic [7:0]                  word_cnt_q;
  logic [15:0]                 pend_q;
  logic [31:0][7:0]            regs_q;
  logic                        locked_q;
  logic                        miso_q;
  logic                        frame_err_q;
  logic                        cmd_valid_q;
  logic [15:0]                 cmd_word_q;
  logic [CW-1:0]               cnt_q;
  logic                        drdy_q;
  logic                        wrap_pend_q;
  logic [NUM_CH*WORD_BITS-1:0] snap_q;

  logic                 sclk_rise, sclk_fall;
  logic                 cs_rise, cs_fall;
  logic                 mosi_s;
  logic [15:0]          cmd;
  logic [WORD_BITS-1:0] next_word;
  logic                 conv_en, wrap;
  logic [15:0]          dec_resp;
  logic                 dec_lock, dec_wr, soft_rst, rst_all;
  logic                 is_unlock, is_lock, is_reset, is_rreg, is_wreg;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign mosi_s    = mosi_q[1];

  assign cmd       = rx_q[WORD_BITS-1 -: 16];
  assign is_unlock = cmd == 16'h0655;
  assign is_lock   = cmd == 16'h0555;
  assign is_reset  = cmd == 16'h0011;
  assign is_rreg   = cmd[15:13] == 3'b001;
  assign is_wreg   = cmd[15:13] == 3'b010;

  assign conv_en = ~locked_q & (regs_q[15][3:0] != 4'h0);
  assign wrap    = cnt_q == CW'(DRDY_PERIOD - 1);
  assign rst_all = reset | soft_rst;

  always_ff @(posedge system_clock) begin
    if (reset) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi.SPI_SCLK};
      cs_q   <= {cs_q[1:0], spi.SPI_CS};
      mosi_q <= {mosi_q[0], spi.SPI_MOSI};
    end
  end

  always_ff @(posedge system_clock) begin
    if (rst_all) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (cs_fall) state_d = S_SHIFT;
      S_SHIFT: begin
        if (cs_rise) begin
          if (bit_cnt_q == '0 && word_cnt_q != 8'd0) state_d = S_DECODE;
          else                                       state_d = S_IDLE;
        end
      end
      S_DECODE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Locked: only NULL, UNLOCK and RREG act; everything else reads as NULL.
  always_comb begin
    dec_resp = {8'h22, regs_q[2]};
    dec_lock = locked_q;
    dec_wr   = 1'b0;
    soft_rst = 1'b0;
    if (state_q == S_DECODE) begin
      unique case (1'b1)
        is_unlock: begin
          dec_lock = 1'b0;
          dec_resp = 16'h0655;
        end
        is_rreg: dec_resp = {3'b001, cmd[12:8], regs_q[cmd[12:8]]};
        (is_lock & ~locked_q): begin
          dec_lock = 1'b1;
          dec_resp = 16'h0555;
        end
        (is_reset & ~locked_q): soft_rst = 1'b1;
        (is_wreg & ~locked_q): begin
          dec_wr   = 1'b1;
          dec_resp = {3'b001, cmd[12:8], cmd[7:0]};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(word_cnt_q) == i) next_word = snap_q[i*WORD_BITS +: WORD_BITS];
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      cmd_valid_q <= 1'b0;
      cmd_word_q  <= 16'h0000;
    end else begin
      cmd_valid_q <= state_q == S_DECODE;
      if (state_q == S_DECODE) cmd_word_q <= cmd;
    end
  end

  always_ff @(posedge system_clock) begin
    if (rst_all) begin
      shift_q     <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= 8'd0;
      pend_q      <= 16'hFF04;
      regs_q      <= '0;
      regs_q[0]   <= REG_ID_MSB;
      locked_q    <= 1'b1;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
      drdy_q      <= 1'b1;
      wrap_pend_q <= 1'b0;
      snap_q      <= '0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            shift_q    <= {pend_q, {(WORD_BITS-16){1'b0}}};
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= 8'd0;
          end
        end
        S_SHIFT: begin
          if (cs_rise) begin
            miso_q <= 1'b0;
            if (bit_cnt_q != '0) frame_err_q <= 1'b1;
          end else begin
            if (sclk_rise) begin
              miso_q  <= shift_q[WORD_BITS-1];
              shift_q <= shift_q << 1;
            end
            if (sclk_fall) begin
              if (word_cnt_q == 8'd0) rx_q <= {rx_q[WORD_BITS-2:0], mosi_s};
              if (bit_cnt_q == BW'(WORD_BITS - 1)) begin
                bit_cnt_q <= '0;
                shift_q   <= next_word;
                if (word_cnt_q != 8'hFF) word_cnt_q <= word_cnt_q + 8'd1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
        end
        S_DECODE: begin
          pend_q   <= dec_resp;
          locked_q <= dec_lock;
          if (dec_wr) regs_q[cmd[12:8]] <= cmd[7:0];
        end
        default: miso_q <= 1'b0;
      endcase

      // A wrap outside IDLE is held so no snapshot lands mid-frame.
      if (!conv_en) begin
        cnt_q       <= '0;
        drdy_q      <= 1'b1;
        wrap_pend_q <= 1'b0;
      end else begin
        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
        if (wrap || wrap_pend_q) begin
          if (state_q == S_IDLE && !cs_fall) begin
            snap_q      <= ch_data;
            drdy_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
          end else begin
            wrap_pend_q <= 1'b1;
          end
        end
      end
      if (state_q == S_IDLE && cs_fall) drdy_q <= 1'b1;
    end
  end

  assign spi.SPI_MISO = miso_q & ~spi.SPI_CS;
  assign drdy_n       = drdy_q;
  assign locked       = locked_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_word     = cmd_word_q;
  assign frame_error  = frame_err_q;

endmodule

// File: tb/tb_ads131a0x_spi_responder.sv
// Bench for ads131a0x_spi_responder: drives SPI frames as the master would.
module tb_ads131a0x_spi_responder;
  localparam int WB = 24;
  localparam int NC = 4;
  localparam int DP = 2000;
  localparam int HP = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             drdy_n, locked, cmd_valid, frame_error;
  logic [15:0]      cmd_word;
  logic [NC*WB-1:0] ch_data;

  ads131a0x_spi_responder_if spi ();

  ads131a0x_spi_responder #(
    .WORD_BITS  (WB),
    .NUM_CH     (NC),
    .DRDY_PERIOD(DP),
    .REG_ID_MSB (8'h04)
  ) dut (
    .system_clock(clk),
    .reset       (rst),
    .spi         (spi),
    .drdy_n      (drdy_n),
    .ch_data     (ch_data),
    .locked      (locked),
    .cmd_valid   (cmd_valid),
    .cmd_word    (cmd_word),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    int          nwords;
    logic [23:0] exp0;
    logic        lk;
  } vec_t;

  vec_t        tbl[11];
  logic [23:0] exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_cv = 0;
  int          n_fe = 0;
  logic [15:0] last_cw = 16'h0;
  logic        drdy_at_start;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        n_cv++;
        last_cw = cmd_word;
      end
      if (frame_error) n_fe++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic spi_frame(input logic [15:0] cmd, input int nbits);
    logic [23:0] tx;
    logic [23:0] rxw;
    int          b;
    tx  = {cmd, 8'h00};
    rxw = '0;
    spi.SPI_CS = 1'b0;
    wait_clk(2*HP);
    drdy_at_start = drdy_n;
    for (int i = 0; i < nbits; i++) begin
      b = i % WB;
      spi.SPI_SCLK = 1'b1;
      spi.SPI_MOSI = (i < WB) ? tx[WB-1-b] : 1'b0;
      wait_clk(HP);
      rxw = {rxw[WB-2:0], spi.SPI_MISO};
      spi.SPI_SCLK = 1'b0;
      wait_clk(HP);
      if (b == WB-1) begin
        if (exp_q.size() > 0)
          chk($sformatf("miso word%0d cmd %h", i/WB, cmd), {8'h0, rxw},
              {8'h0, exp_q.pop_front()});
        else
          chk("unexpected word", exp_q.size(), 1);
      end
    end
    spi.SPI_MOSI = 1'b0;
    wait_clk(HP);
    spi.SPI_CS = 1'b1;
    wait_clk(2*HP);
  endtask

  task automatic run_vec(input vec_t v);
    int cv0;
    exp_q.push_back(v.exp0);
    for (int w = 1; w < v.nwords; w++) exp_q.push_back(24'h0);
    cv0 = n_cv;
    spi_frame(v.cmd, v.nwords*WB);
    chk("leftover expected words", exp_q.size(), 0);
    chk($sformatf("cmd_valid count %h", v.cmd), n_cv - cv0, 1);
    chk($sformatf("cmd_word %h", v.cmd), {16'h0, last_cw}, {16'h0, v.cmd});
    chk($sformatf("locked after %h", v.cmd), {31'h0, locked}, {31'h0, v.lk});
  endtask

  task automatic wait_drdy(input string nm, input int bound);
    int k;
    k = 0;
    while (drdy_n !== 1'b0 && k < bound) begin
      wait_clk(1);
      k++;
    end
    chk(nm, {31'h0, drdy_n}, 0);
  endtask

  initial begin
    int cv0, fe0, lows;
    spi.SPI_CS   = 1'b1;
    spi.SPI_SCLK = 1'b0;
    spi.SPI_MOSI = 1'b0;
    ch_data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};

    tbl[0]  = '{16'h0000, 5, 24'hFF0400, 1'b1};
    tbl[1]  = '{16'h0655, 1, 24'h220000, 1'b0};
    tbl[2]  = '{16'h0000, 1, 24'h065500, 1'b0};
    tbl[3]  = '{16'h4F0F, 1, 24'h220000, 1'b0};
    tbl[4]  = '{16'h2F00, 1, 24'h2F0F00, 1'b0};
    tbl[5]  = '{16'h0000, 1, 24'h2F0F00, 1'b0};
    tbl[6]  = '{16'h0555, 1, 24'h220000, 1'b1};
    tbl[7]  = '{16'h4205, 1, 24'h055500, 1'b1};
    tbl[8]  = '{16'h2F00, 1, 24'h220000, 1'b1};
    tbl[9]  = '{16'h0000, 1, 24'h2F0F00, 1'b1};
    tbl[10] = '{16'h2F00, 1, 24'h220000, 1'b1};

    wait_clk(5);
    chk("reset miso", {31'h0, spi.SPI_MISO}, 0);
    chk("reset drdy_n", {31'h0, drdy_n}, 1);
    chk("reset locked", {31'h0, locked}, 1);
    chk("reset cmd_valid", {31'h0, cmd_valid}, 0);
    chk("reset cmd_word", {16'h0, cmd_word}, 0);
    chk("reset frame_error", {31'h0, frame_error}, 0);
    rst = 1'b0;
    wait_clk(4);

    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i]);
      if (i == 3) wait_drdy("drdy after enable", DP + 3);
      if (i == 5) begin
        wait_drdy("drdy second conversion", 2*DP);
        ch_data = '1;
        exp_q.push_back(24'h220000);
        exp_q.push_back(24'h111111);
        exp_q.push_back(24'h222222);
        exp_q.push_back(24'h333333);
        exp_q.push_back(24'h444444);
        cv0 = n_cv;
        spi_frame(16'h0000, 5*WB);
        chk("drdy_n after cs fall", {31'h0, drdy_at_start}, 1);
        chk("data frame leftover", exp_q.size(), 0);
        chk("data frame cmd_valid", n_cv - cv0, 1);
        cv0 = n_cv;
        fe0 = n_fe;
        spi_frame(16'h4205, 10);
        chk("abort frame_error", n_fe - fe0, 1);
        chk("abort no cmd_valid", n_cv - cv0, 0);
      end
      if (i == 9) begin
        lows = 0;
        for (int k = 0; k < DP + 10; k++) begin
          wait_clk(1);
          if (drdy_n !== 1'b1) lows++;
        end
        chk("no drdy while locked", lows, 0);
      end
    end

    fe0 = n_fe;
    spi.SPI_CS = 1'b0;
    wait_clk(2*HP);
    for (int i = 0; i < 5; i++) begin
      spi.SPI_SCLK = 1'b1;
      spi.SPI_MOSI = 1'b1;
      wait_clk(HP);
      spi.SPI_SCLK = 1'b0;
      wait_clk(HP);
    end
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2*HP);
    chk("miso after mid-frame reset", {31'h0, spi.SPI_MISO}, 0);
    chk("locked after reset", {31'h0, locked}, 1);
    chk("cmd_word after reset", {16'h0, cmd_word}, 0);
    chk("drdy_n after reset", {31'h0, drdy_n}, 1);
    spi.SPI_MOSI = 1'b0;
    spi.SPI_CS = 1'b1;
    wait_clk(2*HP);
    chk("no frame_error on reset", n_fe - fe0, 0);
    run_vec('{16'h0000, 1, 24'hFF0400, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
